bht_table: RTL and testbench

BHT_TABLE -- requirements
Module: bht_table

---
 rtl/bht_table.sv | 99 +++++++++
 tb/tb_bht_table.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bht_table.sv
// Branch history table: 2^BHTBTB_INDEX_WIDTH sets of four 2-bit saturating counters,
// swept to weakly-not-taken after reset, with a 1-cycle registered read and write-first bypass.
module bht_table #(
  parameter int BHTBTB_INDEX_WIDTH = 9
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          bjusb_bht_write_enable,
  input  logic [BHTBTB_INDEX_WIDTH-1:0] bjusb_bht_write_index,
  input  logic [1:0]                    bjusb_bht_write_counter_select,
  input  logic                          bjusb_bht_write_inc,
  input  logic                          bjusb_bht_write_dec,
  input  logic                          bjusb_bht_valid_in,
  input  logic                          bht_read_enable,
  input  logic [BHTBTB_INDEX_WIDTH-1:0] bht_read_index,
  output logic [7:0]                    bht_read_data,
  output logic                          bht_read_valid,
  output logic                          bht_init_done
);

  localparam int SETS = 1 << BHTBTB_INDEX_WIDTH;
  localparam logic [7:0] INIT_SET = 8'h55;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                        r_state;
  logic [BHTBTB_INDEX_WIDTH-1:0] r_init_ptr;
  logic                          r_init_done;
  logic [7:0]                    r_table [SETS];
  logic [7:0]                    r_rd_data_p1;
  logic                          r_rd_vld_p1;

  logic                          w_run;
  logic                          w_wr_accept;
  logic                          w_rd_accept;
  logic [7:0]                    w_wr_old;
  logic [7:0]                    w_wr_new;
  logic [7:0]                    w_rd_fwd;

  function automatic logic [1:0] f_sat_step(input logic [1:0] cnt, input logic inc,
                                            input logic dec);
    logic [1:0] res;
    res = cnt;
    if (inc && !dec && cnt != 2'b11) res = cnt + 2'd1;
    else if (dec && !inc && cnt != 2'b00) res = cnt - 2'd1;
    return res;
  endfunction

  assign w_run       = (r_state == ST_RUN);
  assign w_wr_accept = bjusb_bht_write_enable & bjusb_bht_valid_in & w_run & ~reset;
  assign w_rd_accept = bht_read_enable & w_run;
  assign w_wr_old    = r_table[bjusb_bht_write_index];

  always_comb begin
    w_wr_new = w_wr_old;
    w_wr_new[{bjusb_bht_write_counter_select, 1'b0} +: 2] =
      f_sat_step(w_wr_old[{bjusb_bht_write_counter_select, 1'b0} +: 2],
                 bjusb_bht_write_inc, bjusb_bht_write_dec);
  end

  // A same-index write in this cycle is visible to the read launched in this cycle.
  assign w_rd_fwd = (w_wr_accept && (bjusb_bht_write_index == bht_read_index)) ?
                    w_wr_new : r_table[bht_read_index];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_init_ptr  <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_init_ptr <= r_init_ptr + 1'b1;
      if (r_init_ptr == '1) begin
        r_state     <= ST_RUN;
        r_init_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && r_state == ST_INIT) r_table[r_init_ptr] <= INIT_SET;
    else if (w_wr_accept)             r_table[bjusb_bht_write_index] <= w_wr_new;
  end

  // Stage p1: registered read result
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_vld_p1  <= 1'b0;
      r_rd_data_p1 <= 8'h00;
    end else begin
      r_rd_vld_p1 <= w_rd_accept;
      if (w_rd_accept) r_rd_data_p1 <= w_rd_fwd;
    end
  end

  assign bht_read_data  = r_rd_data_p1;
  assign bht_read_valid = r_rd_vld_p1;
  assign bht_init_done  = r_init_done;

endmodule

// File: tb/tb_bht_table.sv
// Directed bench for bht_table: init sweep timing, saturating updates, bypass and reset restart.
module tb_bht_table;

  localparam int IW = 9;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [1:0]    wr_sel;
  logic          wr_inc;
  logic          wr_dec;
  logic          wr_vld;
  logic          rd_en;
  logic [IW-1:0] rd_idx;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          init_done;

  int n_cmp = 0;
  int n_err = 0;

  bht_table #(.BHTBTB_INDEX_WIDTH(IW)) dut (
    .clock                          (clock),
    .reset                          (reset),
    .bjusb_bht_write_enable         (wr_en),
    .bjusb_bht_write_index          (wr_idx),
    .bjusb_bht_write_counter_select (wr_sel),
    .bjusb_bht_write_inc            (wr_inc),
    .bjusb_bht_write_dec            (wr_dec),
    .bjusb_bht_valid_in             (wr_vld),
    .bht_read_enable                (rd_en),
    .bht_read_index                 (rd_idx),
    .bht_read_data                  (rd_data),
    .bht_read_valid                 (rd_valid),
    .bht_init_done                  (init_done)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_idx = '0; wr_sel = 0; wr_inc = 0; wr_dec = 0; wr_vld = 0;
    rd_en = 0; rd_idx = '0;
  endtask

  // Counts edges after reset release until init_done; returns count (0 on timeout).
  task automatic wait_init(output int cycles, output bit saw_valid);
    cycles = 0;
    saw_valid = 0;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clock); @(negedge clock);
      if (rd_valid) saw_valid = 1;
      if (init_done) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic do_write(input int idx, input int sel, input bit inc, input bit dec,
                          input bit vld);
    wr_en = 1; wr_idx = IW'(idx); wr_sel = 2'(sel); wr_inc = inc; wr_dec = dec; wr_vld = vld;
    @(posedge clock); @(negedge clock);
    idle_inputs();
  endtask

  task automatic do_read(input string tag, input int idx, input logic [7:0] exp);
    rd_en = 1; rd_idx = IW'(idx);
    @(posedge clock); @(negedge clock);
    rd_en = 0;
    check_val({tag, "_vld"}, 32'(rd_valid), 32'd1);
    check_val({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  int cyc;
  bit saw;

  initial begin
    idle_inputs();
    reset = 1;
    @(posedge clock); @(negedge clock);
    check_val("rst_init_done", 32'(init_done), 0);
    check_val("rst_rd_valid", 32'(rd_valid), 0);
    check_val("rst_rd_data", 32'(rd_data), 0);
    reset = 0;
    rd_en = 1; rd_idx = 0;  // read issued during INIT must never return valid
    wait_init(cyc, saw);
    rd_en = 0;
    check_val("init_cycles", 32'(cyc), 512);
    check_val("init_no_valid", 32'(saw), 0);

    do_read("rd0", 0, 8'h55);
    do_read("rd255", 255, 8'h55);
    do_read("rd511", 511, 8'h55);
    @(posedge clock); @(negedge clock);
    check_val("vld_drop", 32'(rd_valid), 0);
    check_val("data_hold", 32'(rd_data), 32'h55);

    for (int i = 0; i < 4; i++) do_write(5, 2, 1, 0, 1);
    do_read("inc_sat", 5, 8'h75);
    for (int i = 0; i < 3; i++) do_write(7, 0, 0, 1, 1);
    do_read("dec_sat", 7, 8'h54);
    do_write(3, 1, 1, 1, 1);
    do_write(4, 1, 1, 0, 0);
    do_read("incdec", 3, 8'h55);
    do_read("no_vld", 4, 8'h55);
    do_write(6, 3, 0, 0, 1);
    do_read("none", 6, 8'h55);

    // Same-index bypass: read and inc of set 9 counter 3 together
    wr_en = 1; wr_vld = 1; wr_idx = 9; wr_sel = 3; wr_inc = 1;
    do_read("bypass", 9, 8'h95);
    idle_inputs();
    // Different indices in the same cycle
    wr_en = 1; wr_vld = 1; wr_idx = 10; wr_sel = 0; wr_inc = 1;
    do_read("diff_rd", 5, 8'h75);
    idle_inputs();
    do_read("diff_wr", 10, 8'h56);

    // Reset mid-stream, with a write and read in the same cycle as reset
    do_write(20, 1, 1, 0, 1);
    reset = 1; wr_en = 1; wr_vld = 1; wr_idx = 0; wr_sel = 0; wr_inc = 1; rd_en = 1;
    @(posedge clock); @(negedge clock);
    reset = 0;
    check_val("rst2_done", 32'(init_done), 0);
    check_val("rst2_vld", 32'(rd_valid), 0);
    check_val("rst2_data", 32'(rd_data), 0);
    // Writes keep hitting early sets during the sweep; all must be dropped
    wr_en = 1; wr_vld = 1; wr_inc = 1; wr_sel = 1; wr_idx = 1; rd_en = 1; rd_idx = 2;
    wait_init(cyc, saw);
    idle_inputs();
    check_val("rst2_cycles", 32'(cyc), 512);
    check_val("rst2_no_valid", 32'(saw), 0);
    do_read("post0", 0, 8'h55);
    do_read("post1", 1, 8'h55);
    do_read("post5", 5, 8'h55);
    do_read("post7", 7, 8'h55);
    do_read("post9", 9, 8'h55);
    do_read("post20", 20, 8'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
